fifo_parity_checker: RTL
========================

// Module: fifo_parity_checker
// PURPOSE
//  Pop-side consumer of the parity FIFO. Takes {data,parity} words off the FIFO pop port and checks parity.
//  Strips the parity bit and buffers words in a 2-entry skid buffer.
//  Presents data downstream on a valid/ready port, with a per-beat error flag, a sticky error and a
//  saturating error counter. Sits directly after the FIFO in the datapath.
// PARAMETERS
//  DATA_WIDTH  8  payload width; FIFO word width is DATA_WIDTH+1
//  EVEN_ODD    0  0 = even parity, 1 = odd parity (same meaning as the encoder)
//  PARITY_BIT  0  0 = parity in bit 0, payload in [DATA_WIDTH:1]; 1 = parity in bit DATA_WIDTH, payload in [DATA_WIDTH-1:0]
//  DROP_BAD    0  0 = forward bad beats with par_err_o=1; 1 = accept and discard bad beats
//  CNT_W       8  width of error counter
// PORTS
//  clk           in   1             single clock, rising edge
//  rst           in   1             synchronous, active-high reset
//  fifo_data_i   in   DATA_WIDTH+1  FIFO pop data (wired to FIFO pop_data_o)
//  fifo_valid_i  in   1             FIFO word available (wired to pop_valid_o)
//  fifo_grant_o  out  1             pop acknowledge (wired to FIFO pop_grant_i)
//  data_o        out  DATA_WIDTH    payload, parity stripped
//  data_valid_o  out  1             data_o/par_err_o valid
//  data_ready_i  in   1             downstream accepts
//  par_err_o     out  1             parity error on current output beat
//  err_sticky_o  out  1             any error since reset/clear
//  err_cnt_o     out  CNT_W         count of bad beats, saturates at all-ones
//  clr_err_i     in   1             clears err_sticky_o and err_cnt_o
// BEHAVIOUR
//  Reset: fifo_grant_o=0 during rst; data_valid_o=0; data_o=0; par_err_o=0; err_sticky_o=0; err_cnt_o=0. Buffer state EMPTY.
//  Upstream transfer: a word is popped on any cycle where fifo_valid_i && fifo_grant_o.
//  fifo_grant_o = !rst && state!=FULL. It depends on registered state only; there is no path from data_ready_i.
//  Parity check on an accepted word: bad = (^payload ^ parity) != EVEN_ODD.
//  Downstream transfer: a beat completes on data_valid_o && data_ready_i. data_o/par_err_o hold steady while valid && !ready.
//  Latency: a word accepted in cycle N is on data_o in cycle N+1 if the buffer was EMPTY.
//  Buffer FSM states: EMPTY, ONE, FULL (2 entries, head/tail regs or 1-bit pointers). Order is FIFO order.
//   EMPTY: wr -> ONE.
//   ONE: wr&!rd -> FULL; rd&!wr -> EMPTY; wr&rd -> ONE (new word becomes head next cycle).
//   FULL: rd -> ONE. No wr is possible because grant=0.
//   wr = accept && !(DROP_BAD && bad). rd = data_valid_o && data_ready_i.
//  data_valid_o = state!=EMPTY. Output fields come from the head entry.
//  DROP_BAD=1: a bad word is popped from the FIFO, never enters the buffer, and is counted.
//  Error accounting: on an accepted bad word, err_sticky_o<=1 and err_cnt_o<=sat(err_cnt_o+1).
//   Updates are visible the cycle after acceptance.
//   clr_err_i and a bad accept in the same cycle: clear first, then count -> cnt=1, sticky=1.
//   Saturation: at all-ones the counter stays put, with no wrap.
//  Reset mid-operation: buffered words are discarded, and the FIFO sees grant=0 during rst.
//  Full throughput: 1 word/cycle sustained while data_ready_i=1.
// STRUCTURE
//  Package fifo_pkg: buffer state enum (EMPTY/ONE/FULL) and a parity_ok() function (data, parity, even_odd).
//  The package is shared with parity_encoder.
//  One sub-module: par_skid_buf (2-entry skid buffer carrying {par_err, payload}).
//  The parity check, drop logic and counters stay in the top.
// TESTING
//  1 Reset: rst=1 for 2 clk -> grant=0, valid=0, cnt=0; after release with fifo_valid_i=0 -> grant=1.
//  2 Even, PARITY_BIT=0: push 0xA5 (word 0x14A, parity 0) with ready=1 -> data_o=0xA5 next cycle, par_err_o=0.
//  3 Corrupt parity (word 0x14B), DROP_BAD=0 -> data_o=0xA5, par_err_o=1, sticky=1, cnt=1.
//  3b Same with DROP_BAD=1 -> no valid beat is produced; cnt=1.
//  4 Backpressure: ready=0, stream 0x01,0x02,0x03 -> grant drops after 2 accepts; 0x03 is held in the FIFO.
//  4b Then ready=1 -> outputs 01,02,03 in order with no loss or duplication.
//  5 CNT_W=2: inject 5 bad words -> cnt saturates at 3.
//  5b clr_err_i together with a 6th bad word -> cnt=1, sticky=1.
//  6 Reset asserted with the buffer FULL -> valid=0 next cycle; stale data never reappears after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and parity helper for the parity FIFO datapath
package fifo_pkg;

   // Widest payload parity_ok() accepts; narrower payloads are zero-extended,
   // which leaves the XOR reduction unchanged.
   localparam int PAR_MAX_W = 64;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_t;

   // True when data and parity together satisfy the selected parity sense
   // (even_odd=0: even number of ones overall, 1: odd number of ones overall).
   function automatic logic parity_ok(input logic [PAR_MAX_W-1:0] data,
                                      input logic                 parity,
                                      input logic                 even_odd);
      return ((^data) ^ parity) == even_odd;
   endfunction

endpackage

// File: rtl/par_skid_buf.sv
// rtl/par_skid_buf.sv - 2-entry in-order skid buffer with registered full/valid
module par_skid_buf
   import fifo_pkg::*;
#(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic         full,
   output logic         valid,
   output logic [W-1:0] rd_data
);

   buf_state_t   state, state_nxt;
   logic [W-1:0] head, tail;
   logic         load_head_wr, load_tail_wr, load_head_tail;

   // Occupancy state register
   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   // Next occupancy and which entry each write/read moves into the head slot
   always_comb begin
      state_nxt      = state;
      load_head_wr   = 1'b0;
      load_tail_wr   = 1'b0;
      load_head_tail = 1'b0;
      case (state)
         EMPTY: begin
            if (wr_en) begin
               state_nxt    = ONE;
               load_head_wr = 1'b1;
            end
         end
         ONE: begin
            if (wr_en && rd_en) begin
               load_head_wr = 1'b1;
            end else if (wr_en) begin
               state_nxt    = FULL;
               load_tail_wr = 1'b1;
            end else if (rd_en) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            // Upstream is stalled while full, so only a read can happen here.
            if (rd_en) begin
               state_nxt      = ONE;
               load_head_tail = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Entry storage; cleared on reset so the output reads zero until first write
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (load_head_wr)        head <= wr_data;
         else if (load_head_tail) head <= tail;
         if (load_tail_wr)        tail <= wr_data;
      end
   end

   assign full    = (state == FULL);
   assign valid   = (state != EMPTY);
   assign rd_data = head;

endmodule

// File: rtl/fifo_parity_checker.sv
// rtl/fifo_parity_checker.sv - FIFO pop-side parity checker with skid buffer and error counters
module fifo_parity_checker
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int EVEN_ODD   = 0,
   parameter int PARITY_BIT = 0,
   parameter int DROP_BAD   = 0,
   parameter int CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH:0]   fifo_data_i,
   input  logic                  fifo_valid_i,
   output logic                  fifo_grant_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  data_valid_o,
   input  logic                  data_ready_i,
   output logic                  par_err_o,
   output logic                  err_sticky_o,
   output logic [CNT_W-1:0]      err_cnt_o,
   input  logic                  clr_err_i
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DATA_WIDTH-1:0] payload;
   logic                  parity_in;
   logic                  buf_full;
   logic                  accept, bad, wr, rd;
   logic [DATA_WIDTH:0]   buf_out;

   // Split the FIFO word into payload and parity according to parity placement
   generate
      if (PARITY_BIT == 0) begin : g_par_lsb
         assign payload   = fifo_data_i[DATA_WIDTH:1];
         assign parity_in = fifo_data_i[0];
      end else begin : g_par_msb
         assign payload   = fifo_data_i[DATA_WIDTH-1:0];
         assign parity_in = fifo_data_i[DATA_WIDTH];
      end
   endgenerate

   // Grant comes from registered state only, keeping data_ready_i off the FIFO path.
   assign fifo_grant_o = !rst && !buf_full;
   assign accept       = fifo_valid_i && fifo_grant_o;
   assign bad          = !parity_ok(PAR_MAX_W'(payload), parity_in, EVEN_ODD != 0);
   assign wr           = accept && !((DROP_BAD != 0) && bad);
   assign rd           = data_valid_o && data_ready_i;

   par_skid_buf #(
      .W(DATA_WIDTH + 1)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr),
      .wr_data ({bad, payload}),
      .rd_en   (rd),
      .full    (buf_full),
      .valid   (data_valid_o),
      .rd_data (buf_out)
   );

   assign par_err_o = buf_out[DATA_WIDTH];
   assign data_o    = buf_out[DATA_WIDTH-1:0];

   // Sticky flag and saturating counter; a clear in the same cycle as a bad
   // accept wipes the old count and then counts the new error.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_sticky_o <= 1'b0;
         err_cnt_o    <= '0;
      end else begin
         if (clr_err_i) begin
            err_sticky_o <= 1'b0;
            err_cnt_o    <= '0;
         end
         if (accept && bad) begin
            err_sticky_o <= 1'b1;
            if (clr_err_i)                 err_cnt_o <= CNT_W'(1);
            else if (err_cnt_o != CNT_MAX) err_cnt_o <= err_cnt_o + CNT_W'(1);
         end
      end
   end

endmodule
